branch_resolve_bht: RTL and testbench
=====================================

// Module: branch_resolve_bht
// PURPOSE
//  EX-stage consumer of the ALU flag outputs (ZF, SF) for the dynamic-branch pipeline.
//  Resolves conditional branches (BEQZ/BNEZ/BLTZ/BGEZ) against the IF-stage prediction.
//  Trains a PC-indexed table of 2-bit saturating counters (BHT).
//  Issues a registered redirect/flush to IF/ID on mispredict; serves IF prediction lookups.
// PARAMETERS
//  INDEX_W    4   BHT index width; table has 2**INDEX_W entries
//  DATA_WIDTH 16  PC / target width
// PORTS
//  clk            in   1        clock, all state on rising edge
//  rst_n          in   1        asynchronous active-low reset
//  if_pc          in   16       IF-stage PC for prediction lookup
//  if_pred_taken  out  1        prediction for if_pc (combinational from table)
//  ex_valid       in   1        EX holds a valid instruction
//  ex_is_branch   in   1        EX instruction is a conditional branch
//  ex_cond        in   2        00 BEQZ, 01 BNEZ, 10 BLTZ, 11 BGEZ
//  ex_stall       in   1        EX frozen this cycle; no resolve, no update
//  ex_pc          in   16       PC of EX branch (BHT update index)
//  ex_pc_plus2    in   16       fall-through address
//  ex_target      in   16       taken-target address
//  ex_pred_taken  in   1        prediction carried down the pipe for this branch
//  alu_zf         in   1        ALU ZF for Rs (Rs+0)
//  alu_sf         in   1        ALU SF for Rs
//  redirect_valid out  1        1-cycle pulse: flush IF/ID, load redirect_pc
//  redirect_pc    out  16       corrected fetch address
//  br_count       out  16       resolved-branch counter (saturating)
//  mispred_count  out  16       mispredict counter (saturating)
// BEHAVIOUR
//  Reset (async, rst_n=0): every BHT entry = 2'b01 (weak not-taken); redirect_valid=0,
//   redirect_pc=0, br_count=0, mispred_count=0. Table and outputs held while rst_n=0.
//  Index = pc[INDEX_W:1] (instructions 2-byte aligned; pc[0] ignored).
//  if_pred_taken = bht[idx(if_pc)][1]; purely combinational, no latency.
//  Resolve event R = ex_valid & ex_is_branch & ~ex_stall & ~redirect_valid.
//   ~redirect_valid term squashes the wrong-path shadow instruction in EX the cycle after a redirect.
//  Actual outcome T: BEQZ=zf, BNEZ=~zf, BLTZ=sf, BGEZ=~sf.
//  On R at edge N:
//   - bht[idx(ex_pc)]: T ? min(c+1,3) : max(c-1,0). States 00 SNT, 01 WNT, 10 WT, 11 ST.
//   - br_count += 1, holds at 16'hFFFF.
//   - if T != ex_pred_taken: redirect_valid=1 in cycle N+1 only; redirect_pc = T ? ex_target : ex_pc_plus2;
//     mispred_count += 1, holds at 16'hFFFF.
//  Without a mispredicting R, redirect_valid returns to 0; redirect_pc keeps its last value.
//  Same-index read/write in one cycle: if_pred_taken shows the pre-update value; the update
//   becomes visible the next cycle.
//  ex_stall=1: no table/counter change, no redirect generated; an already-issued redirect
//   pulse still lasts exactly one cycle.
//  Non-branch or ex_valid=0: no state change.
//  Reset mid-operation: pending redirect dropped immediately; table returns to all-01.
// TESTING
//  1 Reset, then sweep if_pc 0..0x1E -> if_pred_taken=0 everywhere; both counters 0.
//  2 BEQZ @0x0010, zf=1, pred=0, target=0x0040 -> next cycle redirect_valid=1 for 1 cycle,
//    redirect_pc=0x0040; if_pc=0x0010 then predicts 1 (entry 8 = 10); mispred_count=1.
//  3 Repeat 2 with pred=1 three times -> no redirect; entry 8 stays 11; br_count=4.
//  4 BLTZ @0x0022, sf=0, pred=1, pc+2=0x0024 -> redirect_pc=0x0024; entry 1 goes 01->00;
//    the EX branch in the following cycle is ignored (no update, no redirect).
//  5 Mispredicting branch with ex_stall=1 for 3 cycles, then ex_stall=0 -> exactly one update and
//    one redirect, in the cycle after stall drops.
//  6 Drop rst_n mid-redirect -> redirect_valid falls at once (async); counters 0; all entries 01.

Source files
------------

// File: rtl/branch_resolve_bht.sv
// EX-stage conditional-branch resolver with a PC-indexed table of 2-bit saturating counters.
// Issues a registered one-cycle redirect on mispredict and serves combinational IF lookups.
module branch_resolve_bht #(
  parameter int INDEX_W    = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] if_pc,
  output logic                  if_pred_taken,
  input  logic                  ex_valid,
  input  logic                  ex_is_branch,
  input  logic [1:0]            ex_cond,
  input  logic                  ex_stall,
  input  logic [DATA_WIDTH-1:0] ex_pc,
  input  logic [DATA_WIDTH-1:0] ex_pc_plus2,
  input  logic [DATA_WIDTH-1:0] ex_target,
  input  logic                  ex_pred_taken,
  input  logic                  alu_zf,
  input  logic                  alu_sf,
  output logic                  redirect_valid,
  output logic [DATA_WIDTH-1:0] redirect_pc,
  output logic [15:0]           br_count,
  output logic [15:0]           mispred_count
);

  localparam int ENTRIES = 2 ** INDEX_W;

  typedef enum logic [1:0] {
    COND_BEQZ = 2'b00,
    COND_BNEZ = 2'b01,
    COND_BLTZ = 2'b10,
    COND_BGEZ = 2'b11
  } cond_e;

  // Saturating 2-bit counter step toward the actual outcome.
  function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic t);
    logic [1:0] n;
    if (t) begin
      n = (c == 2'b11) ? 2'b11 : c + 2'b01;
    end else begin
      n = (c == 2'b00) ? 2'b00 : c - 2'b01;
    end
    return n;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? 16'hFFFF : v + 16'h0001;
  endfunction

  logic [1:0]         bht_r [ENTRIES];
  logic [INDEX_W-1:0] if_idx_s;
  logic [INDEX_W-1:0] ex_idx_s;
  logic               resolve_s;
  logic               taken_s;
  logic               mispred_s;
  logic               unused_s;

  assign if_idx_s = if_pc[INDEX_W:1];
  assign ex_idx_s = ex_pc[INDEX_W:1];
  assign unused_s = ^{if_pc[DATA_WIDTH-1:INDEX_W+1], if_pc[0],
                      ex_pc[DATA_WIDTH-1:INDEX_W+1], ex_pc[0]};

  // Lookup reads the stored state, so a same-cycle update is seen only next cycle.
  assign if_pred_taken = bht_r[if_idx_s][1];

  // A branch in the shadow of a redirect is on the wrong path and is squashed.
  assign resolve_s = ex_valid & ex_is_branch & ~ex_stall & ~redirect_valid;

  // Actual branch outcome from the ALU flags.
  always_comb begin
    taken_s = 1'b0;
    case (cond_e'(ex_cond))
      COND_BEQZ: taken_s = alu_zf;
      COND_BNEZ: taken_s = ~alu_zf;
      COND_BLTZ: taken_s = alu_sf;
      COND_BGEZ: taken_s = ~alu_sf;
      default:   taken_s = 1'b0;
    endcase
  end

  assign mispred_s = resolve_s & (taken_s != ex_pred_taken);

  // Branch history table training.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        bht_r[i] <= 2'b01;
      end
    end else if (resolve_s) begin
      bht_r[ex_idx_s] <= ctr_next(bht_r[ex_idx_s], taken_s);
    end
  end

  // Redirect pulse and corrected fetch address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= {DATA_WIDTH{1'b0}};
    end else begin
      redirect_valid <= mispred_s;
      if (mispred_s) begin
        redirect_pc <= taken_s ? ex_target : ex_pc_plus2;
      end
    end
  end

  // Saturating resolve and mispredict statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_count      <= 16'h0000;
      mispred_count <= 16'h0000;
    end else begin
      if (resolve_s) begin
        br_count <= sat_inc(br_count);
      end
      if (mispred_s) begin
        mispred_count <= sat_inc(mispred_count);
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_bht.sv
// Directed, table-driven bench for branch_resolve_bht with hand-computed expectations.
module tb_branch_resolve_bht;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] if_pc;
  logic        if_pred_taken;
  logic        ex_valid, ex_is_branch, ex_stall, ex_pred_taken, alu_zf, alu_sf;
  logic [1:0]  ex_cond;
  logic [15:0] ex_pc, ex_pc_plus2, ex_target;
  logic        redirect_valid;
  logic [15:0] redirect_pc, br_count, mispred_count;

  int total = 0;
  int bad   = 0;

  branch_resolve_bht #(.INDEX_W(4), .DATA_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_cond(ex_cond),
    .ex_stall(ex_stall), .ex_pc(ex_pc), .ex_pc_plus2(ex_pc_plus2),
    .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
    .alu_zf(alu_zf), .alu_sf(alu_sf), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .br_count(br_count), .mispred_count(mispred_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic        br;
    logic [1:0]  cond;
    logic        stall;
    logic [15:0] pc;
    logic [15:0] pc2;
    logic [15:0] tgt;
    logic        pred;
    logic        zf;
    logic        sf;
    logic        e_rv;
    logic [15:0] e_rpc;
    logic        e_bp;
  } vec_t;

  vec_t vt [13];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic b, input logic [1:0] c, input logic s,
                       input logic [15:0] pc, input logic [15:0] pc2, input logic [15:0] tgt,
                       input logic p, input logic z, input logic sg);
    ex_valid = v; ex_is_branch = b; ex_cond = c; ex_stall = s;
    ex_pc = pc; ex_pc_plus2 = pc2; ex_target = tgt; ex_pred_taken = p;
    alu_zf = z; alu_sf = sg; if_pc = pc;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 2'b00, 1'b0, 16'h0000, 16'h0002, 16'h0000, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //           valid br    cond   stall  pc        pc2       tgt       pred  zf    sf    rv    rpc       bp
    vt[0]  = '{1'b1, 1'b1, 2'b00, 1'b0, 16'h0010, 16'h0012, 16'h0040, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0040, 1'b1};
    vt[1]  = '{1'b0, 1'b0, 2'b00, 1'b0, 16'h0010, 16'h0012, 16'h0040, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0040, 1'b1};
    vt[2]  = '{1'b1, 1'b1, 2'b00, 1'b0, 16'h0010, 16'h0012, 16'h0040, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0040, 1'b1};
    vt[3]  = '{1'b1, 1'b1, 2'b00, 1'b0, 16'h0010, 16'h0012, 16'h0040, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0040, 1'b1};
    vt[4]  = '{1'b1, 1'b1, 2'b00, 1'b0, 16'h0010, 16'h0012, 16'h0040, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0040, 1'b1};
    vt[5]  = '{1'b1, 1'b1, 2'b10, 1'b0, 16'h0022, 16'h0024, 16'h0080, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0024, 1'b0};
    vt[6]  = '{1'b1, 1'b1, 2'b00, 1'b0, 16'h0004, 16'h0006, 16'h0090, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0024, 1'b0};
    vt[7]  = '{1'b1, 1'b1, 2'b01, 1'b0, 16'h0004, 16'h0006, 16'h0050, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0050, 1'b1};
    vt[8]  = '{1'b1, 1'b1, 2'b11, 1'b0, 16'h0006, 16'h0008, 16'h0066, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0050, 1'b0};
    vt[9]  = '{1'b1, 1'b1, 2'b11, 1'b0, 16'h0006, 16'h0008, 16'h0060, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0060, 1'b1};
    vt[10] = '{1'b1, 1'b0, 2'b11, 1'b0, 16'h0006, 16'h0008, 16'h0060, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0060, 1'b1};
    vt[11] = '{1'b1, 1'b1, 2'b11, 1'b1, 16'h0006, 16'h0008, 16'h0060, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0060, 1'b1};
    vt[12] = '{1'b1, 1'b1, 2'b11, 1'b0, 16'h0006, 16'h0008, 16'h0060, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0008, 1'b0};

    rst_n = 1'b0;
    idle();
    #12;
    check("reset_rv", {15'd0, redirect_valid}, 16'h0000);
    check("reset_rpc", redirect_pc, 16'h0000);
    check("reset_br", br_count, 16'h0000);
    check("reset_mis", mispred_count, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int a = 0; a < 32; a += 2) begin
      if_pc = 16'(a);
      #1;
      check($sformatf("reset_pred_%0h", a), {15'd0, if_pred_taken}, 16'h0000);
    end

    for (int i = 0; i < 13; i++) begin
      drive(vt[i].valid, vt[i].br, vt[i].cond, vt[i].stall, vt[i].pc, vt[i].pc2,
            vt[i].tgt, vt[i].pred, vt[i].zf, vt[i].sf);
      tick();
      check($sformatf("v%0d_rv", i), {15'd0, redirect_valid}, {15'd0, vt[i].e_rv});
      check($sformatf("v%0d_rpc", i), redirect_pc, vt[i].e_rpc);
      check($sformatf("v%0d_pred", i), {15'd0, if_pred_taken}, {15'd0, vt[i].e_bp});
    end
    check("tbl_br", br_count, 16'd8);
    check("tbl_mis", mispred_count, 16'd5);

    // pc[0] and bits above the index are ignored by the lookup
    if_pc = 16'h0011; #1;
    check("pc0_ignored", {15'd0, if_pred_taken}, 16'h0001);
    if_pc = 16'h0030; #1;
    check("alias_idx8", {15'd0, if_pred_taken}, 16'h0001);
    if_pc = 16'h0022; #1;
    check("entry1_snt", {15'd0, if_pred_taken}, 16'h0000);

    // Stalled mispredicting branch: resolves once, after the stall drops
    idle();
    tick();
    check("pre_stall_rv", {15'd0, redirect_valid}, 16'h0000);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b1, 2'b00, 1'b1, 16'h0008, 16'h000A, 16'h0070, 1'b0, 1'b1, 1'b0);
      tick();
      check($sformatf("stall%0d_rv", k), {15'd0, redirect_valid}, 16'h0000);
      check($sformatf("stall%0d_pred", k), {15'd0, if_pred_taken}, 16'h0000);
    end
    check("stall_br", br_count, 16'd8);
    ex_stall = 1'b0;
    #1;
    check("same_cycle_old_pred", {15'd0, if_pred_taken}, 16'h0000);
    tick();
    check("unstall_rv", {15'd0, redirect_valid}, 16'h0001);
    check("unstall_rpc", redirect_pc, 16'h0070);
    check("unstall_pred", {15'd0, if_pred_taken}, 16'h0001);
    ex_stall = 1'b1;
    tick();
    check("pulse_one_cycle", {15'd0, redirect_valid}, 16'h0000);
    check("pulse_rpc_hold", redirect_pc, 16'h0070);
    idle();
    tick();
    check("stall_seq_br", br_count, 16'd9);
    check("stall_seq_mis", mispred_count, 16'd6);

    // Async reset in the middle of a redirect pulse
    drive(1'b1, 1'b1, 2'b01, 1'b0, 16'h000C, 16'h000E, 16'h00A0, 1'b0, 1'b0, 1'b0);
    tick();
    check("pre_rst_rv", {15'd0, redirect_valid}, 16'h0001);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rv", {15'd0, redirect_valid}, 16'h0000);
    check("async_rpc", redirect_pc, 16'h0000);
    check("async_br", br_count, 16'h0000);
    check("async_mis", mispred_count, 16'h0000);
    for (int a = 0; a < 32; a += 2) begin
      if_pc = 16'(a);
      #1;
      check($sformatf("rst_pred_%0h", a), {15'd0, if_pred_taken}, 16'h0000);
    end
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("post_rst_rv", {15'd0, redirect_valid}, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
